// File: rtl/watch_timekeeper_if.sv
// Avalon-MM register bus between the Nios II and the watch timekeeper.
interface watch_timekeeper_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  chipselect;
   logic                  write;
   logic                  read;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;

   modport master (
      output address, chipselect, write, read, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write, read, writedata,
      output readdata
   );
endinterface

// File: rtl/watch_timekeeper.sv
// BCD time-of-day clock driven by the 1 ms tick, with a programmable alarm,
// a ringing FSM, a level interrupt and an Avalon-MM register slave.
module watch_timekeeper #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 2,
   parameter int MS_PER_SEC   = 1000,
   parameter int RING_SECONDS = 60
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick_ms,
   watch_timekeeper_if.slave    bus,
   output logic [23:0]          time_bcd,
   output logic                 alarm_out,
   output logic                 irq
);

   localparam int MS_W   = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
   localparam int RING_W = $clog2(RING_SECONDS + 1);

   localparam logic [MS_W-1:0]       MS_LAST   = MS_W'(MS_PER_SEC - 1);
   localparam logic [RING_W-1:0]     RING_LAST = RING_W'(RING_SECONDS - 1);
   localparam logic [ADDR_WIDTH-1:0] A_TIME    = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_ALARM   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_MS      = ADDR_WIDTH'(3);

   typedef enum logic {IDLE, RING} state_t;

   // One BCD field step: returns {carry, next_field}. Values at or above the
   // field maximum (binary compare) wrap to zero, which also repairs garbage.
   function automatic logic [8:0] bcd_inc(input logic [7:0] f, input logic [7:0] max);
      if (f >= max)
         return {1'b1, 8'h00};
      else if (f[3:0] >= 4'd9)
         return {1'b0, f[7:4] + 4'd1, 4'h0};
      else
         return {1'b0, f[7:4], f[3:0] + 4'd1};
   endfunction

   state_t              state, state_nxt;
   logic [MS_W-1:0]     ms_cnt;
   logic [RING_W-1:0]   ring_cnt;
   logic [7:0]          hh, mm, ss;
   logic [7:0]          hh_n, mm_n, ss_n;
   logic                hh_c, mm_c, ss_c;
   logic [23:0]         alarm_val;
   logic                alarm_en;
   logic                run;
   logic                irq_en;
   logic                alarm_pending;
   logic                sec_inc;
   logic                sec_inc_p1;
   logic                match;
   logic                wr_en, rd_en;
   logic                wr_time, wr_alarm, wr_ctrl;
   logic                stop_ring, pend_clr, alarm_disable;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                unused_wdata;

   assign unused_wdata = ^bus.writedata[DATA_WIDTH-1:25];

   assign wr_en         = bus.chipselect & bus.write;
   assign rd_en         = bus.chipselect & bus.read;
   assign wr_time       = wr_en & (bus.address == A_TIME);
   assign wr_alarm      = wr_en & (bus.address == A_ALARM);
   assign wr_ctrl       = wr_en & (bus.address == A_CTRL);
   assign stop_ring     = wr_ctrl & bus.writedata[3];
   assign pend_clr      = wr_ctrl & bus.writedata[1];
   assign alarm_disable = wr_alarm & ~bus.writedata[24];

   assign sec_inc   = run & tick_ms & (ms_cnt == MS_LAST);
   assign match     = sec_inc_p1 & alarm_en & ({hh, mm, ss} == alarm_val) & (state == IDLE);
   assign time_bcd  = {hh, mm, ss};
   assign alarm_out = (state == RING);

   // Cascaded seconds -> minutes -> hours increment, all in one cycle.
   always_comb begin
      {ss_c, ss_n} = bcd_inc(ss, 8'h59);
      {mm_c, mm_n} = bcd_inc(mm, 8'h59);
      {hh_c, hh_n} = bcd_inc(hh, 8'h23);
   end

   // Millisecond prescaler; a TIME write restarts the current second.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ms_cnt <= '0;
      else if (wr_time)
         ms_cnt <= '0;
      else if (run && tick_ms)
         ms_cnt <= sec_inc ? '0 : ms_cnt + MS_W'(1);
   end

   // Time-of-day register; software load takes priority over the second step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hh <= 8'h00;
         mm <= 8'h00;
         ss <= 8'h00;
      end else if (wr_time) begin
         hh <= bus.writedata[23:16];
         mm <= bus.writedata[15:8];
         ss <= bus.writedata[7:0];
      end else if (sec_inc) begin
         ss <= ss_n;
         if (ss_c) begin
            mm <= mm_n;
            if (mm_c)
               hh <= hh_n;
         end
      end
   end

   // Marks the cycle after a counted second so the alarm compares the new time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         sec_inc_p1 <= 1'b0;
      else
         sec_inc_p1 <= sec_inc & ~wr_time;
   end

   // Software-visible alarm and control registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_val <= 24'h000000;
         alarm_en  <= 1'b0;
         run       <= 1'b1;
         irq_en    <= 1'b0;
      end else begin
         if (wr_alarm) begin
            alarm_val <= bus.writedata[23:0];
            alarm_en  <= bus.writedata[24];
         end
         if (wr_ctrl) begin
            run    <= bus.writedata[0];
            irq_en <= bus.writedata[2];
         end
      end
   end

   // Sticky alarm flag; a match in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         alarm_pending <= 1'b0;
      else if (match)
         alarm_pending <= 1'b1;
      else if (pend_clr)
         alarm_pending <= 1'b0;
   end

   // Level interrupt, registered one cycle behind the pending flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         irq <= 1'b0;
      else
         irq <= alarm_pending & irq_en;
   end

   // Alarm FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Alarm FSM next state: ring on match, stop on timeout or any cancel source.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (match)
               state_nxt = RING;
         end
         RING: begin
            if (stop_ring || alarm_disable || !run)
               state_nxt = IDLE;
            else if (sec_inc && (ring_cnt == RING_LAST))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Seconds rung so far; held at zero while idle so each ring starts fresh.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ring_cnt <= '0;
      else if (state == IDLE)
         ring_cnt <= '0;
      else if (sec_inc)
         ring_cnt <= ring_cnt + RING_W'(1);
   end

   // Register read multiplexer; unused bits are zero.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         A_TIME:  rd_mux[23:0] = {hh, mm, ss};
         A_ALARM: rd_mux[24:0] = {alarm_en, alarm_val};
         A_CTRL:  rd_mux[2:0]  = {irq_en, alarm_pending, run};
         A_MS:    rd_mux[MS_W-1:0] = ms_cnt;
         default: rd_mux = '0;
      endcase
   end

   // Registered read data with one cycle of latency; holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         bus.readdata <= '0;
      else if (rd_en)
         bus.readdata <= rd_mux;
   end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Randomized bench for watch_timekeeper against a field-level reference model.
module tb_watch_timekeeper;

   localparam int MS = 1000;
   localparam int RS = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick_ms = 1'b0;
   logic [23:0] time_bcd;
   logic        alarm_out;
   logic        irq;

   watch_timekeeper_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();

   watch_timekeeper #(
      .DATA_WIDTH(32), .ADDR_WIDTH(2), .MS_PER_SEC(MS), .RING_SECONDS(RS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_ms   (tick_ms),
      .bus       (bus),
      .time_bcd  (time_bcd),
      .alarm_out (alarm_out),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit seen_235959 = 0;

   // reference model state
   int   m_ms, m_hh, m_mm, m_ss, m_al, m_ring_secs;
   bit   m_al_en, m_run, m_irq_en, m_pend, m_irq, m_ring, m_eval;
   logic [31:0] m_rd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fld_next(input int f, input int max);
      if (f >= max) return 0;
      if ((f % 16) >= 9) return (f / 16 + 1) * 16;
      return f + 1;
   endfunction

   function automatic int model_time();
      return m_hh * 65536 + m_mm * 256 + m_ss;
   endfunction

   function automatic logic [31:0] read_val(input int addr);
      case (addr)
         0: return 32'(model_time());
         1: return 32'(m_al) | (m_al_en ? 32'h0100_0000 : 32'h0);
         2: return {29'h0, m_irq_en, m_pend, m_run};
         default: return 32'(m_ms);
      endcase
   endfunction

   task automatic model_reset();
      m_ms = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_al = 0; m_ring_secs = 0;
      m_al_en = 0; m_run = 1; m_irq_en = 0; m_pend = 0; m_irq = 0;
      m_ring = 0; m_eval = 0; m_rd = 32'h0;
   endtask

   // One clock cycle: drive inputs, advance the model, check the outputs.
   task automatic step(input bit tick, input bit wr, input bit rd, input int addr, input logic [31:0] wd);
      bit sec, twr, match, c_s, c_m;
      bus.chipselect = wr | rd;
      bus.write      = wr;
      bus.read       = rd;
      bus.address    = addr[1:0];
      bus.writedata  = wd;
      tick_ms        = tick;

      sec   = m_run && tick && (m_ms == MS - 1);
      twr   = wr && (addr == 0);
      match = m_eval && m_al_en && (model_time() == m_al) && !m_ring;
      if (rd) m_rd = read_val(addr);
      m_irq = m_pend && m_irq_en;
      if (!m_ring) begin
         if (match) begin
            m_ring = 1;
            m_ring_secs = 0;
         end
      end else if ((wr && addr == 2 && wd[3]) || (wr && addr == 1 && !wd[24]) || !m_run) begin
         m_ring = 0;
      end else if (sec) begin
         m_ring_secs++;
         if (m_ring_secs == RS) m_ring = 0;
      end
      if (match) m_pend = 1;
      else if (wr && addr == 2 && wd[1]) m_pend = 0;
      m_eval = sec && !twr;
      if (twr) m_ms = 0;
      else if (m_run && tick) m_ms = (m_ms + 1) % MS;
      if (twr) begin
         m_hh = int'(wd[23:16]); m_mm = int'(wd[15:8]); m_ss = int'(wd[7:0]);
      end else if (sec) begin
         c_s = (m_ss >= 'h59);
         m_ss = fld_next(m_ss, 'h59);
         if (c_s) begin
            c_m = (m_mm >= 'h59);
            m_mm = fld_next(m_mm, 'h59);
            if (c_m) m_hh = fld_next(m_hh, 'h23);
         end
      end
      if (wr && addr == 1) begin
         m_al = int'(wd[23:0]);
         m_al_en = wd[24];
      end
      if (wr && addr == 2) begin
         m_run = wd[0];
         m_irq_en = wd[2];
      end

      @(posedge clk);
      #1;
      if (time_bcd == 24'h235959) seen_235959 = 1;
      check_val("time_bcd", 32'(time_bcd), 32'(model_time()));
      check_val("alarm_out", 32'(alarm_out), 32'(m_ring));
      check_val("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         step(1, 0, 0, 0, 32'h0);
      end
   endtask

   task automatic wr_reg(input int addr, input logic [31:0] d);
      step(0, 1, 0, addr, d);
   endtask

   task automatic rd_reg(input string tag, input int addr);
      step(0, 0, 1, addr, 32'h0);
      check_val(tag, bus.readdata, m_rd);
   endtask

   initial begin
      logic [31:0] t, a;
      int f;
      bus.chipselect = 0; bus.write = 0; bus.read = 0;
      bus.address = '0; bus.writedata = '0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_time_bcd", 32'(time_bcd), 32'h0);
      check_val("rst_alarm_out", 32'(alarm_out), 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      check_val("rst_readdata", bus.readdata, 32'h0);
      reset_n = 1'b1;
      rd_reg("rst_TIME", 0);
      rd_reg("rst_ALARM", 1);
      rd_reg("rst_CTRL", 2);
      check_val("rst_CTRL_const", bus.readdata, 32'h1);
      rd_reg("rst_MS", 3);

      // midnight rollover
      wr_reg(0, 32'h0023_5958);
      ticks(2000);
      rd_reg("wrap_TIME", 0);
      check_val("wrap_TIME_const", bus.readdata, 32'h0);
      rd_reg("wrap_MS", 3);
      check_val("seen_235959", 32'(seen_235959), 32'h1);

      // TIME write collides with a second boundary
      wr_reg(0, 32'h0000_0005);
      ticks(MS - 1);
      step(1, 1, 0, 0, 32'h0000_0009);
      rd_reg("collide_TIME", 0);
      check_val("collide_TIME_const", bus.readdata, 32'h9);
      rd_reg("collide_MS", 3);
      ticks(MS);
      rd_reg("collide_next_TIME", 0);
      check_val("collide_next_const", bus.readdata, 32'h10);

      // alarm match, timed ring, pending stays, clear drops irq
      wr_reg(1, 32'h0112_0000);
      wr_reg(2, 32'h5);
      wr_reg(0, 32'h0011_5959);
      ticks(MS);
      idle(2);
      check_val("ring_alarm_out", 32'(alarm_out), 32'h1);
      check_val("ring_irq", 32'(irq), 32'h1);
      ticks(RS * MS);
      idle(2);
      check_val("ring_end_alarm_out", 32'(alarm_out), 32'h0);
      rd_reg("ring_end_CTRL", 2);
      check_val("ring_end_CTRL_const", bus.readdata, 32'h7);
      wr_reg(2, 32'h2);
      idle(2);
      check_val("clr_irq", 32'(irq), 32'h0);
      rd_reg("clr_CTRL", 2);

      // stop_ring pulse during RING
      wr_reg(2, 32'h5);
      wr_reg(0, 32'h0012_0010);
      wr_reg(1, 32'h0112_0011);
      ticks(MS);
      idle(2);
      wr_reg(2, 32'hD);
      check_val("stop_alarm_out", 32'(alarm_out), 32'h0);
      rd_reg("stop_CTRL", 2);
      check_val("stop_CTRL_const", bus.readdata, 32'h7);

      // alarm_en cleared during RING
      wr_reg(0, 32'h0012_0020);
      wr_reg(1, 32'h0112_0021);
      ticks(MS);
      idle(2);
      wr_reg(1, 32'h0012_0021);
      check_val("disable_alarm_out", 32'(alarm_out), 32'h0);

      // stopped clock, then out-of-range seconds self-correct
      wr_reg(2, 32'h0);
      ticks(5000);
      rd_reg("frozen_TIME", 0);
      rd_reg("frozen_MS", 3);
      wr_reg(2, 32'h1);
      wr_reg(0, 32'h0000_0075);
      ticks(MS);
      rd_reg("fix_TIME", 0);
      check_val("fix_TIME_const", bus.readdata, 32'h100);

      // randomized register traffic and counting
      for (int it = 0; it < 16; it++) begin
         t = {8'h0, 8'($urandom_range(0, 'h25)), 8'($urandom_range(0, 'h5f)), 8'($urandom_range(0, 'h5f))};
         f = fld_next(int'(t[7:0]), 'h59);
         a = ($urandom_range(0, 1) == 1) ? {8'h0, t[23:8], 8'(f)} : 32'($urandom_range(0, 'h235959));
         a[24] = ($urandom_range(0, 3) != 0);
         wr_reg(2, {28'h0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0)});
         wr_reg(0, t);
         wr_reg(1, a);
         ticks($urandom_range(200, 1200));
         if ($urandom_range(0, 1) == 1) wr_reg(2, {28'h0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1});
         ticks($urandom_range(0, 1200));
         rd_reg("rnd_TIME", 0);
         rd_reg("rnd_ALARM", 1);
         rd_reg("rnd_CTRL", 2);
         rd_reg("rnd_MS", 3);
      end

      // asynchronous reset in the middle of a ring
      wr_reg(2, 32'h5);
      wr_reg(0, 32'h0008_0000);
      wr_reg(1, 32'h0108_0001);
      ticks(MS);
      idle(2);
      check_val("pre_rst_alarm_out", 32'(alarm_out), 32'h1);
      check_val("pre_rst_irq", 32'(irq), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("async_rst_alarm_out", 32'(alarm_out), 32'h0);
      check_val("async_rst_irq", 32'(irq), 32'h0);
      check_val("async_rst_time", 32'(time_bcd), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rd_reg("post_rst_CTRL", 2);
      rd_reg("post_rst_ALARM", 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/watch_timekeeper.md
Name: watch_timekeeper

Overview:
- Downstream consumer of the 1 ms tick produced by the system millisecond timer.
- Turns ms ticks into a BCD time of day (HH:MM:SS, 24 h) and compares it against a programmable alarm.
- Drives an alarm output and interrupt.
- Exposes TIME, ALARM, CTRL/STATUS and MS registers to the Nios II over an Avalon-MM slave, and presents time_bcd to the seven-segment driver.

Parameters:
- DATA_WIDTH, 32, Avalon data width.
- ADDR_WIDTH, 2, Avalon word address width (4 registers).
- MS_PER_SEC, 1000, tick_ms pulses per second.
- RING_SECONDS, 60, maximum alarm ring duration in seconds.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- tick_ms  in  1  one-cycle pulse every 1 ms from the upstream timer.
- address  in  ADDR_WIDTH  register select.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- read  in  1  read strobe, qualified by chipselect.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  registered read data.
- time_bcd  out  24  {HH,MM,SS} BCD, to display.
- alarm_out  out  1  high while ringing (buzzer/LED).
- irq  out  1  level interrupt: alarm_pending & irq_en.

Behaviour:
- Reset and clocking:
  - Reset is reset_n, asynchronous, active-low; clock is clk. All state is cleared asynchronously.
  - Reset values: time=0x000000, alarm=0x000000, alarm_en=0, run=1, irq_en=0, alarm_pending=0, ms_cnt=0, FSM=IDLE, readdata=0, alarm_out=0, irq=0.
- Register map (word addresses):
  - 0 TIME, RW: [23:16] HH, [15:8] MM, [7:0] SS, in BCD.
  - 1 ALARM, RW: [23:0] same format as TIME; [24] alarm_en.
  - 2 CTRL, RW: [0] run, [1] alarm_pending (write 1 to clear), [2] irq_en, [3] stop_ring (write-only pulse, reads 0).
  - 3 MS, RO: [9:0] ms_cnt. Writes are ignored.
- Register reads:
  - Read latency is 1: readdata is updated on the clock edge after chipselect&read; otherwise it holds its value.
  - Unused bits read 0.
- Millisecond and seconds counting:
  - When run=1 and tick_ms=1, ms_cnt increments.
  - At ms_cnt==MS_PER_SEC-1 the count wraps to 0 and raises sec_inc for one cycle.
  - When run=0, ms_cnt and time freeze.
- BCD increment, applied per field:
  - If the field is >= its max (SS/MM max 0x59, HH max 0x23, compared as binary), it becomes 0x00 and carries to the next field.
  - Else if the low nibble is >= 9, the low nibble becomes 0 and the high nibble increments.
  - Else the low nibble increments.
  - Carries cascade SS→MM→HH within the same cycle. 23:59:59 wraps to 00:00:00.
  - Out-of-range written values are not rejected; they self-correct through the rule above.
- time_bcd equals the TIME register, with no extra latency.
- Software writes:
  - A write to TIME loads the fields and clears ms_cnt in the same cycle.
  - A TIME write wins over a simultaneous sec_inc (that increment is dropped).
- Alarm match:
  - Evaluated on the cycle after time changes due to sec_inc (not after software writes).
  - Match condition: alarm_en=1, time==alarm[23:0], and FSM=IDLE.
  - On a match: alarm_pending is set and the FSM goes to RING.
- Alarm FSM:
  - IDLE: alarm_out=0.
  - RING: alarm_out=1. ring_cnt starts at 0 on entry and increments on each sec_inc.
  - RING→IDLE when ring_cnt reaches RING_SECONDS, on stop_ring, on a write of alarm_en=0, or on run=0.
- alarm_pending:
  - Set by match and cleared by a CTRL write with bit1=1.
  - A set and a clear in the same cycle leave it set.
  - Independent of the FSM; it stays set after ringing ends.
- irq is registered: irq = alarm_pending & irq_en, with 1 cycle latency.
- Reset asserted mid-ring drops alarm_out and irq immediately (asynchronous).

Test Plan:
- Reset, then read all 4 registers → TIME=0, ALARM=0, CTRL=0x1, MS=0; alarm_out=0, irq=0.
- Write TIME=0x235958, apply 2000 tick_ms pulses → TIME reads 0x000000 and MS=0; time_bcd passes through 0x235959.
- Write TIME=0x000009 with a sec_inc in the same cycle → TIME=0x000009, MS=0; after 1000 ticks TIME=0x000010.
- Write ALARM=0x01000000|0x120000, CTRL=0x5, TIME=0x115959, apply 1000 ticks → alarm_out=1 and irq=1 one cycle after the match; with RING_SECONDS=3, alarm_out=0 after 3 more seconds; alarm_pending stays 1; CTRL write 0x2 → irq=0.
- During RING, write CTRL bit3=1 → alarm_out=0 the next cycle; alarm_pending unchanged.
- Write CTRL=0x0 (run=0), apply 5000 ticks → TIME and MS unchanged. Write TIME=0x000075 with run=1, apply 1000 ticks → TIME=0x000100.
